// File: rtl/uart_stream_wb8_pkg.sv
// Shared definitions for the UART stream bridge.
// Holds the uart_wb8 register map, the status bit positions, the
// bridge FSM state encoding and a helper that turns the poll gap
// parameter into a counter load value.
package uart_stream_wb8_pkg;

    // uart_wb8 register map
    localparam logic [1:0] UART_ADR_DATA   = 2'd0;
    localparam logic [1:0] UART_ADR_STATUS = 2'd1;

    // uart_wb8 status register bit positions
    localparam int UART_BIT_RXAVAIL = 0;
    localparam int UART_BIT_TXBUSY  = 1;

    // Bridge FSM states
    typedef enum logic [2:0] {
        ST_GAP    = 3'd0,
        ST_POLL   = 3'd1,
        ST_DECIDE = 3'd2,
        ST_RD     = 3'd3,
        ST_WR     = 3'd4
    } state_t;

    // Poll gap load value, saturated to the 8-bit counter range
    function automatic logic [7:0] gap_load(input int unsigned gap);
        logic [7:0] load_v;
        if (gap > 32'd255) begin
            load_v = 8'd255;
        end else begin
            load_v = gap[7:0];
        end
        return load_v;
    endfunction

endpackage

// File: rtl/wb8_master_port.sv
// Single-transaction Wishbone 8-bit master port.
// A request (req with adr/we/dat) is registered onto the bus with
// stb=1 and held stable until ack is sampled; stb drops on that edge.
// A new request is only accepted while stb is low, so there is always
// at least one stb-low cycle between transactions.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   req, req_adr,
//   req_we, req_dat   transaction request from the owner FSM
//   done, rdata       completion strobe (ack cycle) and read data
//   wb_*              Wishbone signals towards the slave
module wb8_master_port
    import uart_stream_wb8_pkg::*;
#(
    parameter logic [1:0] RESET_ADR = UART_ADR_STATUS
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req,
    input  logic [1:0] req_adr,
    input  logic       req_we,
    input  logic [7:0] req_dat,
    output logic       done,
    output logic [7:0] rdata,
    output logic [1:0] wb_adr,
    output logic [7:0] wb_dat,
    output logic       wb_stb,
    output logic       wb_we,
    input  logic       wb_ack,
    input  logic [7:0] wb_rdat
);

    logic       stb_r;
    logic [1:0] adr_r;
    logic       we_r;
    logic [7:0] dat_r;

    // Bus cycle sequencing: launch on request while idle, hold until ack
    always_ff @(posedge clk) begin
        if (reset) begin
            stb_r <= 1'b0;
            adr_r <= RESET_ADR;
            we_r  <= 1'b0;
            dat_r <= 8'd0;
        end else if (stb_r) begin
            if (wb_ack) begin
                stb_r <= 1'b0;
            end else begin
                stb_r <= 1'b1;
            end
        end else if (req) begin
            stb_r <= 1'b1;
            adr_r <= req_adr;
            we_r  <= req_we;
            dat_r <= req_dat;
        end else begin
            stb_r <= 1'b0;
        end
    end

    assign wb_stb = stb_r;
    assign wb_adr = adr_r;
    assign wb_we  = we_r;
    assign wb_dat = dat_r;
    assign done   = stb_r & wb_ack;
    assign rdata  = wb_rdat;

endmodule

// File: rtl/uart_stream_wb8.sv
// Stream-to-UART bridge: a Wishbone 8-bit master that continuously
// polls the uart_wb8 status register and moves bytes between a TX
// valid/ready stream, the UART data register and an RX valid/ready
// stream. Each side has a one-entry holding register; at most one data
// transfer follows each poll, with received data taking priority.
// Ports:
//   I_clk, I_reset                 clock, synchronous active-high reset
//   O_wb_adr/dat/stb/we, I_wb_dat,
//   I_wb_ack                       Wishbone master towards uart_wb8
//   I_tx_data/valid, O_tx_ready    byte stream to transmit
//   O_rx_data/valid, I_rx_ready    received byte stream
module uart_stream_wb8
    import uart_stream_wb8_pkg::*;
#(
    parameter logic [1:0]  ADR_DATA    = UART_ADR_DATA,
    parameter logic [1:0]  ADR_STATUS  = UART_ADR_STATUS,
    parameter int          BIT_RXAVAIL = UART_BIT_RXAVAIL,
    parameter int          BIT_TXBUSY  = UART_BIT_TXBUSY,
    parameter int unsigned POLL_GAP    = 0
) (
    input  logic       I_clk,
    input  logic       I_reset,
    output logic [1:0] O_wb_adr,
    output logic [7:0] O_wb_dat,
    input  logic [7:0] I_wb_dat,
    output logic       O_wb_stb,
    output logic       O_wb_we,
    input  logic       I_wb_ack,
    input  logic [7:0] I_tx_data,
    input  logic       I_tx_valid,
    output logic       O_tx_ready,
    output logic [7:0] O_rx_data,
    output logic       O_rx_valid,
    input  logic       I_rx_ready
);

    localparam logic [7:0] GAP_LOAD = gap_load(POLL_GAP);

    state_t     state_r;
    state_t     state_s;
    logic [7:0] gap_cnt_r;
    logic [7:0] status_r;
    logic       tx_full_r;
    logic [7:0] tx_data_r;
    logic       rx_full_r;
    logic [7:0] rx_data_r;

    logic       req_s;
    logic [1:0] req_adr_s;
    logic       req_we_s;
    logic       done_s;
    logic [7:0] rdata_s;

    wb8_master_port #(
        .RESET_ADR (ADR_STATUS)
    ) u_port (
        .clk     (I_clk),
        .reset   (I_reset),
        .req     (req_s),
        .req_adr (req_adr_s),
        .req_we  (req_we_s),
        .req_dat (tx_data_r),
        .done    (done_s),
        .rdata   (rdata_s),
        .wb_adr  (O_wb_adr),
        .wb_dat  (O_wb_dat),
        .wb_stb  (O_wb_stb),
        .wb_we   (O_wb_we),
        .wb_ack  (I_wb_ack),
        .wb_rdat (I_wb_dat)
    );

    // FSM state register
    always_ff @(posedge I_clk) begin
        if (I_reset) begin
            state_r <= ST_GAP;
        end else begin
            state_r <= state_s;
        end
    end

    // Next state and bus request; RX is checked before TX in DECIDE
    always_comb begin
        state_s   = state_r;
        req_s     = 1'b0;
        req_adr_s = ADR_STATUS;
        req_we_s  = 1'b0;
        case (state_r)
            ST_GAP: begin
                if (gap_cnt_r == 8'd0) begin
                    state_s = ST_POLL;
                end else begin
                    state_s = ST_GAP;
                end
            end
            ST_POLL: begin
                req_s     = 1'b1;
                req_adr_s = ADR_STATUS;
                if (done_s) begin
                    state_s = ST_DECIDE;
                end else begin
                    state_s = ST_POLL;
                end
            end
            ST_DECIDE: begin
                if (status_r[BIT_RXAVAIL] && !rx_full_r) begin
                    state_s = ST_RD;
                end else if (tx_full_r && !status_r[BIT_TXBUSY]) begin
                    state_s = ST_WR;
                end else begin
                    state_s = ST_GAP;
                end
            end
            ST_RD: begin
                req_s     = 1'b1;
                req_adr_s = ADR_DATA;
                if (done_s) begin
                    state_s = ST_GAP;
                end else begin
                    state_s = ST_RD;
                end
            end
            ST_WR: begin
                req_s     = 1'b1;
                req_adr_s = ADR_DATA;
                req_we_s  = 1'b1;
                if (done_s) begin
                    state_s = ST_GAP;
                end else begin
                    state_s = ST_WR;
                end
            end
            default: begin
                state_s = ST_GAP;
            end
        endcase
    end

    // Poll gap counter: reloaded on every entry into GAP
    always_ff @(posedge I_clk) begin
        if (I_reset) begin
            gap_cnt_r <= GAP_LOAD;
        end else if ((state_r != ST_GAP) && (state_s == ST_GAP)) begin
            gap_cnt_r <= GAP_LOAD;
        end else if ((state_r == ST_GAP) && (gap_cnt_r != 8'd0)) begin
            gap_cnt_r <= gap_cnt_r - 8'd1;
        end else begin
            gap_cnt_r <= gap_cnt_r;
        end
    end

    // Latched UART status from the most recent poll
    always_ff @(posedge I_clk) begin
        if (I_reset) begin
            status_r <= 8'd0;
        end else if ((state_r == ST_POLL) && done_s) begin
            status_r <= rdata_s;
        end else begin
            status_r <= status_r;
        end
    end

    // TX holding register; a byte offered on the write-ack cycle waits
    // one cycle because ready is still low then
    always_ff @(posedge I_clk) begin
        if (I_reset) begin
            tx_full_r <= 1'b0;
            tx_data_r <= 8'd0;
        end else if ((state_r == ST_WR) && done_s) begin
            tx_full_r <= 1'b0;
        end else if (I_tx_valid && !tx_full_r) begin
            tx_full_r <= 1'b1;
            tx_data_r <= I_tx_data;
        end else begin
            tx_full_r <= tx_full_r;
        end
    end

    // RX holding register; RD only runs while empty, so fill and drain
    // never coincide
    always_ff @(posedge I_clk) begin
        if (I_reset) begin
            rx_full_r <= 1'b0;
            rx_data_r <= 8'd0;
        end else if ((state_r == ST_RD) && done_s) begin
            rx_full_r <= 1'b1;
            rx_data_r <= rdata_s;
        end else if (rx_full_r && I_rx_ready) begin
            rx_full_r <= 1'b0;
        end else begin
            rx_full_r <= rx_full_r;
        end
    end

    assign O_tx_ready = ~tx_full_r;
    assign O_rx_valid = rx_full_r;
    assign O_rx_data  = rx_data_r;

endmodule
